colour_mode_ctrl: RTL and testbench

COLOUR_MODE_CTRL -- requirements
Module: colour_mode_ctrl

---
 rtl/colour_mode_ctrl_if.sv | 19 +
 rtl/colour_mode_ctrl.sv | 102 ++++++++++
 tb/tb_colour_mode_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/colour_mode_ctrl_if.sv
// Configuration handshake between a host and the colour-mode controller.
// The host offers a mode and auto bit. The controller answers with ready and an illegal-mode error pulse.
interface colour_mode_ctrl_if;
  logic       i_cfg_valid;
  logic [2:0] i_cfg_mode;
  logic       i_cfg_auto;
  logic       o_cfg_ready;
  logic       o_cfg_err;

  modport master (
    output i_cfg_valid, i_cfg_mode, i_cfg_auto,
    input  o_cfg_ready, o_cfg_err
  );

  modport slave (
    input  i_cfg_valid, i_cfg_mode, i_cfg_auto,
    output o_cfg_ready, o_cfg_err
  );
endinterface

// File: rtl/colour_mode_ctrl.sv
// Selects the channel permutation for the colour-swap datapath.
// Mode changes are deferred to vsync rising edges, and an optional auto-cycle steps the mode every N frames.
module colour_mode_ctrl #(
  parameter int unsigned DEFAULT_MODE    = 1,
  parameter int unsigned FRAMES_PER_STEP = 60,
  parameter int unsigned FCNT_WIDTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  colour_mode_ctrl_if.slave     cfg,
  input  logic                  i_vid_vsync,
  output logic [2:0]            o_mode,
  output logic                  o_mode_update,
  output logic                  o_auto,
  output logic [FCNT_WIDTH-1:0] o_frame_cnt
);

  typedef enum logic {IDLE, PENDING} state_t;

  localparam logic [2:0]            RESET_MODE = 3'(DEFAULT_MODE);
  localparam logic [7:0]            STEP_LAST  = 8'(FRAMES_PER_STEP - 1);
  localparam logic [FCNT_WIDTH-1:0] FCNT_ONE   = FCNT_WIDTH'(1);

  state_t                state_reg;
  logic                  vs_d_reg;
  logic [2:0]            mode_reg;
  logic                  auto_reg;
  logic                  update_reg;
  logic                  err_reg;
  logic [7:0]            step_reg;
  logic [2:0]            pend_mode_reg;
  logic                  pend_auto_reg;
  logic [FCNT_WIDTH-1:0] frame_cnt_reg;
  logic                  boundary;
  logic [2:0]            next_mode;

  assign boundary  = i_vid_vsync & ~vs_d_reg;
  assign next_mode = (mode_reg == 3'd5) ? 3'd0 : mode_reg + 3'd1;

  assign cfg.o_cfg_ready = (state_reg == IDLE);
  assign cfg.o_cfg_err   = err_reg;
  assign o_mode          = mode_reg;
  assign o_mode_update   = update_reg;
  assign o_auto          = auto_reg;
  assign o_frame_cnt     = frame_cnt_reg;

  // vs_d resets high so a vsync already asserted at reset release is not taken as a frame start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      vs_d_reg      <= 1'b1;
      mode_reg      <= RESET_MODE;
      auto_reg      <= 1'b0;
      update_reg    <= 1'b0;
      err_reg       <= 1'b0;
      step_reg      <= 8'd0;
      pend_mode_reg <= 3'd0;
      pend_auto_reg <= 1'b0;
      frame_cnt_reg <= '0;
    end else begin
      vs_d_reg   <= i_vid_vsync;
      update_reg <= 1'b0;
      err_reg    <= 1'b0;
      if (boundary) begin
        frame_cnt_reg <= frame_cnt_reg + FCNT_ONE;
      end
      case (state_reg)
        IDLE: begin
          // A transfer in the same cycle as a boundary suppresses that boundary's auto step.
          if (cfg.i_cfg_valid) begin
            if (cfg.i_cfg_mode > 3'd5) begin
              err_reg <= 1'b1;
            end else begin
              pend_mode_reg <= cfg.i_cfg_mode;
              pend_auto_reg <= cfg.i_cfg_auto;
              state_reg     <= PENDING;
            end
          end else if (boundary && auto_reg) begin
            if (step_reg == STEP_LAST) begin
              mode_reg   <= next_mode;
              update_reg <= 1'b1;
              step_reg   <= 8'd0;
            end else begin
              step_reg <= step_reg + 8'd1;
            end
          end
        end
        PENDING: begin
          if (boundary) begin
            mode_reg   <= pend_mode_reg;
            auto_reg   <= pend_auto_reg;
            update_reg <= 1'b1;
            step_reg   <= 8'd0;
            state_reg  <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_colour_mode_ctrl.sv
// Directed bench for colour_mode_ctrl, with a frame-level reference model that is checked every cycle.
// It uses a short frame counter so that counter wrap-around is exercised.
module tb_colour_mode_ctrl;

  localparam int FPS = 2;
  localparam int FW  = 4;

  logic          clk;
  logic          rst;
  logic          vsync;
  logic [2:0]    mode;
  logic          mode_update;
  logic          auto_on;
  logic [FW-1:0] frame_cnt;

  colour_mode_ctrl_if cfg_bus();

  colour_mode_ctrl #(
    .DEFAULT_MODE   (1),
    .FRAMES_PER_STEP(FPS),
    .FCNT_WIDTH     (FW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg          (cfg_bus),
    .i_vid_vsync  (vsync),
    .o_mode       (mode),
    .o_mode_update(mode_update),
    .o_auto       (auto_on),
    .o_frame_cnt  (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s got %0d want %0d at %0t", name, got, want, $time);
    end
  endtask

  // Reference model: requests wait in a queue until the next frame start.
  // Auto-cycle steps once every FPS frame starts, counted since the last mode change.
  typedef struct {
    int mode;
    int en;
  } req_t;

  req_t q[$];
  int   m_mode    = 1;
  int   m_auto    = 0;
  int   m_frames  = 0;
  int   m_since   = 0;
  int   m_upd     = 0;
  int   m_err     = 0;
  bit   m_vs_prev = 1'b1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_mode    = 1;
      m_auto    = 0;
      m_frames  = 0;
      m_since   = 0;
      m_upd     = 0;
      m_err     = 0;
      m_vs_prev = 1'b1;
    end else begin
      bit   start;
      req_t r;
      start     = vsync && !m_vs_prev;
      m_vs_prev = vsync;
      m_upd     = 0;
      m_err     = 0;
      if (start) m_frames++;
      if (q.size() > 0) begin
        if (start) begin
          r       = q.pop_front();
          m_mode  = r.mode;
          m_auto  = r.en;
          m_upd   = 1;
          m_since = 0;
        end
      end else if (cfg_bus.i_cfg_valid) begin
        if (cfg_bus.i_cfg_mode > 5) begin
          m_err = 1;
        end else begin
          r.mode = int'(cfg_bus.i_cfg_mode);
          r.en   = int'(cfg_bus.i_cfg_auto);
          q.push_back(r);
        end
      end else if (start && m_auto != 0) begin
        m_since++;
        if (m_since == FPS) begin
          m_mode  = (m_mode + 1) % 6;
          m_upd   = 1;
          m_since = 0;
        end
      end
    end
  end

  always @(posedge clk) begin
    #3;
    check("ready",     int'(cfg_bus.o_cfg_ready), (q.size() == 0) ? 1 : 0);
    check("err",       int'(cfg_bus.o_cfg_err), m_err);
    check("mode",      int'(mode), m_mode);
    check("update",    int'(mode_update), m_upd);
    check("auto",      int'(auto_on), m_auto);
    check("frame_cnt", int'(frame_cnt), m_frames % (1 << FW));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One full frame: vsync low for two cycles, then its rising edge is clocked.
  task automatic frame();
    vsync = 1'b0;
    cyc();
    cyc();
    vsync = 1'b1;
    cyc();
  endtask

  task automatic request(input logic [2:0] md, input logic en);
    cfg_bus.i_cfg_valid = 1'b1;
    cfg_bus.i_cfg_mode  = md;
    cfg_bus.i_cfg_auto  = en;
    cyc();
    cfg_bus.i_cfg_valid = 1'b0;
  endtask

  initial begin
    rst                 = 1'b1;
    vsync               = 1'b1;
    cfg_bus.i_cfg_valid = 1'b0;
    cfg_bus.i_cfg_mode  = 3'd0;
    cfg_bus.i_cfg_auto  = 1'b0;
    repeat (3) cyc();
    rst = 1'b0;
    repeat (3) cyc();
    check("lit_rst_mode", int'(mode), 1);
    check("lit_rst_fcnt", int'(frame_cnt), 0);
    check("lit_rst_ready", int'(cfg_bus.o_cfg_ready), 1);

    // Mid-frame request, applied at the next vsync rise.
    vsync = 1'b0;
    cyc();
    request(3'd3, 1'b0);
    check("lit_pend_ready", int'(cfg_bus.o_cfg_ready), 0);
    check("lit_pend_mode", int'(mode), 1);
    vsync = 1'b1;
    cyc();
    check("lit_apply_mode", int'(mode), 3);
    check("lit_apply_upd", int'(mode_update), 1);
    cyc();
    check("lit_apply_upd_clr", int'(mode_update), 0);
    check("lit_apply_ready", int'(cfg_bus.o_cfg_ready), 1);

    // Illegal mode request.
    request(3'd7, 1'b0);
    check("lit_err", int'(cfg_bus.o_cfg_err), 1);
    check("lit_err_mode", int'(mode), 3);
    check("lit_err_ready", int'(cfg_bus.o_cfg_ready), 1);
    cyc();
    check("lit_err_clr", int'(cfg_bus.o_cfg_err), 0);

    // Auto-cycle from mode 5, stepping every two frames.
    vsync = 1'b0;
    cyc();
    request(3'd5, 1'b1);
    frame();
    check("lit_auto_apply", int'(mode), 5);
    check("lit_auto_on", int'(auto_on), 1);
    frame();
    check("lit_auto_hold", int'(mode), 5);
    frame();
    check("lit_auto_wrap", int'(mode), 0);
    check("lit_auto_upd", int'(mode_update), 1);
    frame();
    frame();
    check("lit_auto_step", int'(mode), 1);

    // A request at the same edge where an auto step is due wins.
    frame();
    vsync = 1'b0;
    cyc();
    cyc();
    vsync = 1'b1;
    request(3'd2, 1'b0);
    check("lit_race_mode", int'(mode), 1);
    check("lit_race_upd", int'(mode_update), 0);
    frame();
    check("lit_race_apply", int'(mode), 2);
    check("lit_race_auto", int'(auto_on), 0);

    // Seven more frames take the 4-bit count from 9 through 15 and around to 0.
    repeat (7) frame();
    check("lit_fcnt_wrap", int'(frame_cnt), 0);

    // A reset while a request is pending discards the request.
    vsync = 1'b0;
    cyc();
    request(3'd4, 1'b0);
    check("lit_rstp_pend", int'(cfg_bus.o_cfg_ready), 0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("lit_rstp_mode", int'(mode), 1);
    check("lit_rstp_ready", int'(cfg_bus.o_cfg_ready), 1);
    frame();
    frame();
    check("lit_rstp_after", int'(mode), 1);
    check("lit_rstp_fcnt", int'(frame_cnt), 2);
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
